// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
// Pure declarations: no logic, no latency, no backpressure.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (buttons, switches).
// Latency 2 clk cycles; no backpressure.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (r) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces a raw push-button into a clean level plus one-cycle rise/fall strobes.
// Level/strobe change DEBOUNCE_CYCLES+2 edges after a steady input change; no backpressure.
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic r,
    input  logic btn_raw,
    output logic btn_clean,
    output logic pulse_rise,
    output logic pulse_fall
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 btn_s2;
    btn_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 clean_q;
    logic                 rise_q;
    logic                 fall_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .r   (r),
        .d   (btn_raw),
        .q   (btn_s2)
    );

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // Strobes live for one cycle; only a qualifying transition re-arms them.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                IDLE_LOW: begin
                    cnt_q <= '0;
                    if (btn_s2) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_s2) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    cnt_q <= '0;
                    if (!btn_s2) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (btn_s2) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_clean  = clean_q;
    assign pulse_rise = rise_q;
    assign pulse_fall = fall_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with a short debounce window and a toggle flip-flop model.
module tb_btn_pulse_gen;
    import btn_pkg::*;

    localparam int unsigned N = SIM_DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic r;
    logic btn_raw;
    logic btn_clean;
    logic pulse_rise;
    logic pulse_fall;
    logic tff_q;

    int n_checks = 0;
    int n_fail   = 0;
    int both_hi  = 0;

    typedef struct {
        logic r;
        logic btn;
        logic clean;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .r          (r),
        .btn_raw    (btn_raw),
        .btn_clean  (btn_clean),
        .pulse_rise (pulse_rise),
        .pulse_fall (pulse_fall)
    );

    // Lab11 toggle flip-flop, T driven by the rise strobe on the same clock.
    always_ff @(posedge clk) begin
        if (r)
            tff_q <= 1'b0;
        else if (pulse_rise)
            tff_q <= ~tff_q;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic rr, input logic bb);
        r       = rr;
        btn_raw = bb;
        @(posedge clk);
        #1;
        if (pulse_rise && pulse_fall)
            both_hi++;
    endtask

    function automatic void add(input logic rr, input logic bb, input logic c,
                                input logic ri, input logic fa);
        vec_t v;
        v.r = rr; v.btn = bb; v.clean = c; v.rise = ri; v.fall = fa;
        vecs.push_back(v);
    endfunction

    initial begin
        int rises;
        int toggles;
        int s2_highs;
        int bad;
        logic prev_q;
        logic b;
        logic bounce [6];

        r       = 1'b1;
        btn_raw = 1'b0;

        // Reset, clean press, hold, clean release.
        add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < N + 2; i++) add(0, 1, 0, 0, 0);   // E0..E5
        add(0, 1, 1, 1, 0);                                   // E6
        add(0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0);
        for (int i = 0; i < N + 2; i++) add(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].btn);
            chk($sformatf("vec%0d_clean", i), int'(btn_clean),  int'(vecs[i].clean));
            chk($sformatf("vec%0d_rise", i),  int'(pulse_rise), int'(vecs[i].rise));
            chk($sformatf("vec%0d_fall", i),  int'(pulse_fall), int'(vecs[i].fall));
            if (i == 0) begin
                chk("reset_state", int'(dut.state_q), int'(IDLE_LOW));
                chk("reset_cnt",   int'(dut.cnt_q),   0);
                chk("reset_s2",    int'(dut.u_sync.q), 0);
            end
        end

        // Bounce 1,1,0,1,1,0 then steady 1: the only rise lands 6 edges after the last 0->1.
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rises = 0;
        for (int k = 0; k < 19; k++) begin
            b = (k < 6) ? bounce[k] : 1'b1;
            step(1'b0, b);
            if (pulse_rise) rises++;
            chk($sformatf("bounce_rise_k%0d", k), int'(pulse_rise), (k == 12) ? 1 : 0);
        end
        chk("bounce_rise_count", rises, 1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("bounce_released", int'(btn_clean), 0);

        // Three press/release cycles into the toggle flip-flop.
        step(1'b1, 1'b0);
        chk("tff_reset", int'(tff_q), 0);
        rises = 0;
        toggles = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 10; k++) begin
                prev_q = tff_q;
                step(1'b0, 1'b1);
                if (pulse_rise) rises++;
                if (tff_q != prev_q) toggles++;
            end
            chk($sformatf("tff_q_press%0d", p), int'(tff_q), (p % 2 == 0) ? 1 : 0);
            for (int k = 0; k < 10; k++) begin
                prev_q = tff_q;
                step(1'b0, 1'b0);
                if (pulse_rise) rises++;
                if (tff_q != prev_q) toggles++;
            end
        end
        chk("tff_rise_count", rises, 3);
        chk("tff_toggles", toggles, 3);

        // Reset while WAIT_HIGH holds cnt=3, with the button still pressed.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
        chk("midcount_state", int'(dut.state_q), int'(WAIT_HIGH));
        chk("midcount_cnt",   int'(dut.cnt_q),   3);
        step(1'b1, 1'b1);
        chk("midrst_state", int'(dut.state_q), int'(IDLE_LOW));
        chk("midrst_cnt",   int'(dut.cnt_q),   0);
        chk("midrst_outs",  int'({btn_clean, pulse_rise, pulse_fall}), 0);
        rises = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1);
            if (pulse_rise) rises++;
            chk($sformatf("post_rst_rise_k%0d", k), int'(pulse_rise), (k == 6) ? 1 : 0);
        end
        chk("post_rst_rise_count", rises, 1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("post_rst_released", int'(btn_clean), 0);

        // Single-cycle glitch: visible on s2 for one cycle, filtered out entirely.
        s2_highs = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k == 0) ? 1'b1 : 1'b0);
            if (dut.u_sync.q) s2_highs++;
            if (btn_clean || pulse_rise || pulse_fall) bad++;
        end
        chk("glitch_s2_highs", s2_highs, 1);
        chk("glitch_outputs", bad, 0);

        chk("rise_fall_exclusive", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Upstream conditioning stage for the lab11 toggle flip-flop.
- Takes the raw, bouncy, asynchronous push-button (btnC) and produces a clean debounced level plus single-cycle rise/fall strobes, all synchronous to the system clock.
- The rise strobe drives the toggle flip-flop's T input while that flip-flop runs on the system clock. Each button press then toggles Q exactly once, with no bounce-induced multiple toggles.

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive cycles the synchronized input must differ from the current clean level before the clean level changes. Legal range is >= 1; the default is 10 ms at 100 MHz.
- CNT_WIDTH, derived localparam = $clog2(DEBOUNCE_CYCLES+1): stability counter width. Not user-overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset; synchronous, active-high.
- btn_raw  input  1  raw button pin; asynchronous, may bounce.
- btn_clean  output  1  debounced, synchronized button level.
- pulse_rise  output  1  one-cycle strobe on the debounced 0->1 transition (feeds T).
- pulse_fall  output  1  one-cycle strobe on the debounced 1->0 transition.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is r. With r=1 at a rising edge, the following are all cleared:
  - sync stages s1/s2 = 0
  - cnt = 0
  - state = IDLE_LOW
  - btn_clean = 0, pulse_rise = 0, pulse_fall = 0
- Reset priority: r overrides all other activity, including mid-count; a partially counted press is discarded.
- Synchronizer: s1 <= btn_raw, s2 <= s1. Only s2 is used downstream, never btn_raw directly.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: cnt=0. If s2=1, go to WAIT_HIGH with cnt <= 1.
  - WAIT_HIGH:
    - If s2=0, return to IDLE_LOW with cnt <= 0 (bounce rejected).
    - Else if cnt == DEBOUNCE_CYCLES, go to IDLE_HIGH, btn_clean <= 1, pulse_rise <= 1.
    - Else cnt <= cnt+1.
  - IDLE_HIGH: cnt=0. If s2=0, go to WAIT_LOW with cnt <= 1.
  - WAIT_LOW: mirror of WAIT_HIGH. On completion, go to IDLE_LOW, btn_clean <= 0, pulse_fall <= 1.
- Strobes are registered and high for exactly one cycle: they are cleared on the next edge unconditionally. pulse_rise and pulse_fall are never high together.
- Latency:
  - Edge E0 is the first edge at which btn_raw=1 is sampled into s1.
  - s2=1 after E1; the FSM enters WAIT_HIGH at E2.
  - btn_clean and pulse_rise go high at edge E(DEBOUNCE_CYCLES+2), with btn_raw held steady throughout.
  - Release is symmetric.
- Any glitch on s2 during WAIT_* restarts qualification from the IDLE state. The counter never wraps: its maximum value is DEBOUNCE_CYCLES, which CNT_WIDTH covers.
- DEBOUNCE_CYCLES=1 is legal: the FSM passes through WAIT_* for one cycle.
- Button held through reset: after r drops, the press is qualified normally and yields exactly one pulse_rise.

Decomposition:
- Package btn_pkg:
  - FSM state enum (2-bit: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW)
  - constant DEFAULT_DEBOUNCE_CYCLES = 1_000_000
  - constant SIM_DEBOUNCE_CYCLES = 4
- Sub-module sync_2ff: two-flop synchronizer with clk, r, d, q; reset value 0. Reusable for other board inputs (switches).
- The FSM and counter stay in btn_pulse_gen.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: r=1 for 2 cycles, then r=0. Raise btn_raw before edge E0 and hold. -> btn_clean=0 and pulse_rise=0 through E5; at E6 btn_clean=1 and pulse_rise=1; at E7 pulse_rise=0 and btn_clean stays 1.
- Bounce rejection: btn_raw pattern 1,1,0,1,1,0 (one value per cycle), then steady 1. -> no pulse_rise during bouncing; exactly one pulse_rise occurs 6 edges after the last 0->1 transition.
- Release: from held state, drop btn_raw and hold. -> pulse_fall=1 and btn_clean=0 at E6 after the drop; pulse_rise stays 0.
- Chained to the toggle flip-flop: 3 full press/release cycles, with pulse_rise driving T on the same clk. -> Q sequence 0->1->0->1, exactly 3 toggles and 3 pulse_rise strobes total.
- Reset mid-count: assert r while in WAIT_HIGH with cnt=3. -> the next edge gives state IDLE_LOW, cnt=0, all outputs 0. With btn_raw still 1, a single pulse_rise follows 6 edges after r deasserts.
- Short glitch: btn_raw high for exactly 1 cycle. -> s2 shows a 1-cycle high; btn_clean and both strobes stay 0 for 20 cycles.
